// File: rtl/voice_sequencer.sv
// Time-shares one envelope/volume datapath across three voices per sample tick,
// accumulating the scaled outputs into a single mix word with overrun/timeout flags.
module voice_sequencer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tick_i,
  input  logic [2:0]  voice_en_i,
  input  logic [29:0] waves_i,
  input  logic [2:0]  gate_i,
  input  logic [47:0] adsr_i,
  output logic        env_start_o,
  output logic [1:0]  env_voice_idx_o,
  output logic [9:0]  env_wave_o,
  output logic        env_gate_o,
  output logic [3:0]  env_attack_o,
  output logic [3:0]  env_decay_o,
  output logic [3:0]  env_sustain_o,
  output logic [3:0]  env_release_o,
  input  logic        env_ready_i,
  input  logic [9:0]  env_wave_i,
  output logic [11:0] mix_o,
  output logic        mix_valid_o,
  output logic        busy_o,
  output logic        overrun_o,
  output logic        timeout_o,
  input  logic        err_clr_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [9:0]  wave_q, wave_d;
  logic        gate_q, gate_d;
  logic [15:0] adsr_q, adsr_d;
  logic [11:0] acc_q, acc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [11:0] mix_q, mix_d;
  logic        mix_valid_q, mix_valid_d;
  logic        overrun_q, overrun_d;
  logic        timeout_q, timeout_d;

  logic [2:0]  first_sel, next_sel;
  logic        latch;
  logic [1:0]  lat_idx;
  logic        advance;
  logic [11:0] contrib;
  logic        timeout_set;
  logic        overrun_set;

  // Returns {found, index} of the lowest enabled voice at or above lo.
  function automatic logic [2:0] pick(input logic [2:0] mask, input int lo);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 2; i >= 0; i--) begin
      if (mask[i] && i >= lo) res = {1'b1, 2'(i)};
    end
    return res;
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wave_d      = wave_q;
    gate_d      = gate_q;
    adsr_d      = adsr_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    mix_d       = mix_q;
    mix_valid_d = 1'b0;
    latch       = 1'b0;
    lat_idx     = 2'd0;
    advance     = 1'b0;
    contrib     = 12'd0;
    timeout_set = 1'b0;
    first_sel   = pick(voice_en_i, 0);
    next_sel    = pick(voice_en_i, int'(idx_q) + 1);

    case (state_q)
      IDLE: begin
        if (tick_i) begin
          if (first_sel[2]) begin
            latch   = 1'b1;
            lat_idx = first_sel[1:0];
            acc_d   = 12'd0;
            cnt_d   = 8'd0;
            state_d = START;
          end else begin
            mix_d       = 12'd0;
            mix_valid_d = 1'b1;
          end
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        // Ready beats the timeout when both land in the same cycle.
        if (env_ready_i) begin
          contrib = {2'b00, env_wave_i};
          advance = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          timeout_set = 1'b1;
          advance     = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
        if (advance) begin
          acc_d = acc_q + contrib;
          if (next_sel[2]) begin
            latch   = 1'b1;
            lat_idx = next_sel[1:0];
            cnt_d   = 8'd0;
            state_d = START;
          end else begin
            mix_d       = acc_q + contrib;
            mix_valid_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (latch) begin
      idx_d  = lat_idx;
      wave_d = waves_i[10*int'(lat_idx) +: 10];
      gate_d = gate_i[lat_idx];
      adsr_d = adsr_i[16*int'(lat_idx) +: 16];
    end

    overrun_set = tick_i && (state_q != IDLE);
    overrun_d   = overrun_set ? 1'b1 : (err_clr_i ? 1'b0 : overrun_q);
    timeout_d   = timeout_set ? 1'b1 : (err_clr_i ? 1'b0 : timeout_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      wave_q      <= 10'd0;
      gate_q      <= 1'b0;
      adsr_q      <= 16'd0;
      acc_q       <= 12'd0;
      cnt_q       <= 8'd0;
      mix_q       <= 12'd0;
      mix_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wave_q      <= wave_d;
      gate_q      <= gate_d;
      adsr_q      <= adsr_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mix_q       <= mix_d;
      mix_valid_q <= mix_valid_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end

  assign env_start_o     = (state_q == START);
  assign busy_o          = (state_q != IDLE);
  assign env_voice_idx_o = idx_q;
  assign env_wave_o      = wave_q;
  assign env_gate_o      = gate_q;
  assign env_attack_o    = adsr_q[15:12];
  assign env_decay_o     = adsr_q[11:8];
  assign env_sustain_o   = adsr_q[7:4];
  assign env_release_o   = adsr_q[3:0];
  assign mix_o           = mix_q;
  assign mix_valid_o     = mix_valid_q;
  assign overrun_o       = overrun_q;
  assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_voice_sequencer.sv
// Directed bench for voice_sequencer: an envelope model answers start pulses and a
// scoreboard of expected voice indices and mix words is checked as the DUT responds.
module tb_voice_sequencer;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        tick_i = 1'b0;
  logic [2:0]  voice_en_i = 3'b000;
  logic [29:0] waves_i = '0;
  logic [2:0]  gate_i = 3'b000;
  logic [47:0] adsr_i = '0;
  logic        env_start_o;
  logic [1:0]  env_voice_idx_o;
  logic [9:0]  env_wave_o;
  logic        env_gate_o;
  logic [3:0]  env_attack_o, env_decay_o, env_sustain_o, env_release_o;
  logic        env_ready_i = 1'b0;
  logic [9:0]  env_wave_i = '0;
  logic [11:0] mix_o;
  logic        mix_valid_o;
  logic        busy_o;
  logic        overrun_o;
  logic        timeout_o;
  logic        err_clr_i = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  int exp_idx[$];
  int exp_mix[$];
  int start_cyc[$];

  logic [2:0] withhold = 3'b000;
  bit         mode_pass = 1'b0;
  bit         pend = 1'b0;
  int         pend_cd = 0;
  logic [1:0] pend_idx = 2'd0;
  logic [9:0] pend_wave = 10'd0;

  voice_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .tick_i(tick_i), .voice_en_i(voice_en_i),
    .waves_i(waves_i), .gate_i(gate_i), .adsr_i(adsr_i),
    .env_start_o(env_start_o), .env_voice_idx_o(env_voice_idx_o),
    .env_wave_o(env_wave_o), .env_gate_o(env_gate_o),
    .env_attack_o(env_attack_o), .env_decay_o(env_decay_o),
    .env_sustain_o(env_sustain_o), .env_release_o(env_release_o),
    .env_ready_i(env_ready_i), .env_wave_i(env_wave_i),
    .mix_o(mix_o), .mix_valid_o(mix_valid_o), .busy_o(busy_o),
    .overrun_o(overrun_o), .timeout_o(timeout_o), .err_clr_i(err_clr_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Envelope model: ready three cycles after start, unless the voice is withheld.
  always @(negedge clk) begin
    env_ready_i = 1'b0;
    if (pend) begin
      pend_cd--;
      if (pend_cd == 0) begin
        env_ready_i = 1'b1;
        env_wave_i  = mode_pass ? pend_wave : 10'(100 * (int'(pend_idx) + 1));
        pend        = 1'b0;
      end
    end
    if (env_start_o === 1'b1 && !withhold[env_voice_idx_o]) begin
      pend      = 1'b1;
      pend_cd   = 3;
      pend_idx  = env_voice_idx_o;
      pend_wave = env_wave_o;
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (env_start_o === 1'b1) begin
      start_cyc.push_back(cyc);
      if (exp_idx.size() == 0) check("unexpected_start", 1, 0);
      else check("start_idx", int'(env_voice_idx_o), exp_idx.pop_front());
      check("start_wave", int'(env_wave_o), int'(waves_i[10*int'(env_voice_idx_o) +: 10]));
      check("start_adsr", int'({env_attack_o, env_decay_o, env_sustain_o, env_release_o}),
            int'(adsr_i[16*int'(env_voice_idx_o) +: 16]));
      check("start_gate", int'(env_gate_o), int'(gate_i[env_voice_idx_o]));
    end
    if (mix_valid_o === 1'b1) begin
      if (exp_mix.size() == 0) check("unexpected_mix", 1, 0);
      else check("mix_value", int'(mix_o), exp_mix.pop_front());
    end
  end

  task automatic pulse_tick();
    tick_i = 1'b1;
    @(negedge clk);
    tick_i = 1'b0;
  endtask

  task automatic wait_mix(input int n0, output int n);
    n = n0;
    while (mix_valid_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (mix_valid_o !== 1'b1) check("wait_mix_expired", 0, 1);
  endtask

  task automatic step(input int k);
    for (int i = 0; i < k; i++) @(negedge clk);
  endtask

  int n;

  initial begin
    waves_i = {10'd777, 10'd555, 10'd333};
    gate_i  = 3'b101;
    adsr_i  = {16'hFEDC, 16'h89AB, 16'h1234};
    step(3);
    rst_i = 1'b0;
    step(1);
    check("rst_busy", int'(busy_o), 0);
    check("rst_mix", int'(mix_o), 0);
    check("rst_valid", int'(mix_valid_o), 0);
    check("rst_env_wave", int'(env_wave_o), 0);
    check("rst_flags", int'({overrun_o, timeout_o, env_start_o}), 0);

    // All three voices, model returns 100/200/300.
    voice_en_i = 3'b111;
    exp_idx = '{0, 1, 2};
    exp_mix.push_back(600);
    start_cyc.delete();
    pulse_tick();
    check("t1_start_next_cycle", int'(env_start_o), 1);
    check("t1_busy", int'(busy_o), 1);
    wait_mix(1, n);
    check("t1_latency", n, 13);
    check("t1_busy_done", int'(busy_o), 0);
    check("t1_spacing01", start_cyc[1] - start_cyc[0], 4);
    check("t1_spacing12", start_cyc[2] - start_cyc[1], 4);
    step(1);
    check("t1_valid_one_cycle", int'(mix_valid_o), 0);
    check("t1_mix_hold", int'(mix_o), 600);

    // Mask 101 with full-scale waves passed through.
    waves_i   = {10'd1023, 10'd1023, 10'd1023};
    mode_pass = 1'b1;
    voice_en_i = 3'b101;
    exp_idx = '{0, 2};
    exp_mix.push_back(2046);
    pulse_tick();
    wait_mix(1, n);
    check("t2_latency", n, 9);
    mode_pass = 1'b0;
    step(2);

    // No voices enabled.
    voice_en_i = 3'b000;
    exp_mix.push_back(0);
    pulse_tick();
    check("t3_valid", int'(mix_valid_o), 1);
    check("t3_mix", int'(mix_o), 0);
    check("t3_busy", int'(busy_o), 0);
    step(2);

    // Tick during WAIT is dropped and flagged.
    waves_i = {10'd777, 10'd555, 10'd333};
    voice_en_i = 3'b111;
    exp_idx = '{0, 1, 2};
    exp_mix.push_back(600);
    pulse_tick();
    step(1);
    pulse_tick();
    check("t4_overrun_set", int'(overrun_o), 1);
    wait_mix(3, n);
    check("t4_latency", n, 13);
    step(3);
    check("t4_no_restart", int'(busy_o), 0);
    check("t4_overrun_sticky", int'(overrun_o), 1);
    exp_idx = '{0, 1, 2};
    exp_mix.push_back(600);
    pulse_tick();
    step(1);
    tick_i = 1'b1;
    err_clr_i = 1'b1;
    @(negedge clk);
    tick_i = 1'b0;
    err_clr_i = 1'b0;
    check("t4_set_beats_clr", int'(overrun_o), 1);
    wait_mix(3, n);
    step(1);
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    check("t4_overrun_cleared", int'(overrun_o), 0);

    // Voice 1 never answers; TIMEOUT_CYCLES = 8.
    withhold = 3'b010;
    exp_idx = '{0, 1, 2};
    exp_mix.push_back(400);
    pulse_tick();
    step(12);
    check("t5_timeout_pre", int'(timeout_o), 0);
    step(1);
    check("t5_timeout_set", int'(timeout_o), 1);
    check("t5_voice2_start", int'(env_start_o), 1);
    wait_mix(14, n);
    check("t5_latency", n, 18);
    withhold = 3'b000;
    step(1);
    check("t5_timeout_sticky", int'(timeout_o), 1);

    // Reset mid-WAIT of voice 1 with both flags set.
    exp_idx = '{0, 1};
    pulse_tick();
    step(1);
    pulse_tick();
    step(3);
    check("t6_in_wait_v1", int'(env_voice_idx_o), 1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("t6_busy", int'(busy_o), 0);
    check("t6_valid", int'(mix_valid_o), 0);
    check("t6_mix", int'(mix_o), 0);
    check("t6_flags", int'({overrun_o, timeout_o, env_start_o}), 0);
    check("t6_env", int'({env_voice_idx_o, env_wave_o, env_gate_o, env_attack_o,
                          env_decay_o, env_sustain_o, env_release_o}), 0);
    step(5);
    exp_idx = '{0, 1, 2};
    exp_mix.push_back(600);
    pulse_tick();
    wait_mix(1, n);
    check("t6_restart_latency", n, 13);
    step(2);

    check("idx_queue_empty", exp_idx.size(), 0);
    check("mix_queue_empty", exp_mix.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/voice_sequencer.md
# voice_sequencer

Per-sample scheduler that time-shares the single envelope/volume datapath between the three voices. On each sample tick it walks the enabled voices in order 0→1→2. For each voice it latches that voice's raw wave, gate and ADSR nibbles onto the envelope inputs, pulses start, and waits for ready. It sums the returned scaled waves into one mix word and flags tick overruns and envelope timeouts. It sits between the voice register file / wave generators and the mixer/filter stage.

## Interface
- TIMEOUT_CYCLES, default 64: maximum WAIT cycles per voice before abandoning it (range 4..255).

- clk_i  in  1  system clock; single clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- tick_i  in  1  one-cycle sample strobe.
- voice_en_i  in  3  per-voice enable; bit n = voice n.
- waves_i  in  30  raw waves; voice n at [10n+9:10n].
- gate_i  in  3  per-voice gate.
- adsr_i  in  48  voice n at [16n+15:16n] = {attack, decay, sustain, release}.
- env_start_o  out  1  one-cycle start pulse to envelope.
- env_voice_idx_o  out  2  voice index presented to envelope.
- env_wave_o  out  10  latched raw wave.
- env_gate_o  out  1  latched gate.
- env_attack_o, env_decay_o, env_sustain_o, env_release_o  out  4 each  latched ADSR nibbles.
- env_ready_i  in  1  envelope done pulse.
- env_wave_i  in  10  envelope scaled output; valid when env_ready_i=1.
- mix_o  out  12  unsigned sum of processed voices.
- mix_valid_o  out  1  one-cycle pulse; mix_o updated.
- busy_o  out  1  high while a sample is in progress.
- overrun_o  out  1  sticky: tick arrived while busy.
- timeout_o  out  1  sticky: a voice hit TIMEOUT_CYCLES.
- err_clr_i  in  1  clears overrun_o and timeout_o.

## Operation
- States: IDLE, START, WAIT.
- IDLE, tick_i=1, with an enabled voice present:
  - select the lowest enabled index;
  - latch idx, that voice's wave, gate and ADSR into env_* registers;
  - clear the accumulator and the timeout counter;
  - go to START.
- IDLE, tick_i=1, voice_en_i=0: mix_o←0, mix_valid_o pulse, stay IDLE.
- START: env_start_o=1 for exactly this cycle; go to WAIT.
- WAIT, env_ready_i=1:
  - acc += zero-extended env_wave_i (12-bit, no overflow possible: 3×1023=3069);
  - if a higher enabled voice remains: latch its config, counter←0, go to START;
  - otherwise mix_o←acc+env_wave_i, mix_valid_o pulse, go to IDLE.
- WAIT, no ready, counter = TIMEOUT_CYCLES-1: voice contributes 0, timeout_o←1, advance exactly as for ready.
  - env_ready_i wins over timeout in the same cycle.
- env_ready_i outside WAIT is ignored.
- Enable mask, gate, ADSR and wave are sampled only when a voice's config is latched.
  - Mid-sample changes take effect for voices not yet latched.
  - Disabled voices are skipped entirely: their envelope state does not advance and they contribute 0.
- env_* outputs hold their last latched values between samples.
- busy_o = (state ≠ IDLE).
- tick_i while busy_o=1: ignored, overrun_o←1.
- Sticky flags: set takes priority over err_clr_i in the same cycle.
- rst_i, any state, including mid-sample:
  - state←IDLE;
  - all outputs←0 (mix_o, mix_valid_o, env_start_o, env_*, busy_o, overrun_o, timeout_o);
  - accumulator and counter←0;
  - an in-flight sample is dropped with no mix_valid_o.

## Timing
- All outputs registered; reset value 0.
- Tick in cycle T: env_start_o=1 and env_* valid in T+1; busy_o=1 from T+1.
- Ready for voice k in cycle R: next voice's env_start_o in R+1 (one-cycle gap, no bubble beyond START).
- Last ready in cycle R: mix_valid_o=1 and new mix_o in R+1; busy_o=0 in R+1; a tick in R+1 is accepted.
- Per-voice cost: 1 (START) + W cycles in WAIT, where W = envelope latency after start, W ≥ 1.
- Sample latency = Σ(1+W) over enabled voices + 1.
- All-disabled tick in T: mix_valid_o in T+1.
- Timeout: the voice leaves WAIT after TIMEOUT_CYCLES WAIT cycles; timeout_o=1 the following cycle.

## Test plan
- Model envelope returns ready 3 cycles after start, returning 100, 200, 300 for voices 0, 1, 2; mask 3'b111; tick → three starts with idx 0, 1, 2 at 4-cycle spacing → mix_o=600, mix_valid_o one cycle, 13 cycles after the tick.
- Mask 3'b101, waves 1023 returned unchanged → only idx 0 and 2 started; idx 1 never presented → mix_o=2046.
- Mask 3'b000, tick → no env_start_o; mix_valid_o next cycle with mix_o=0.
- Second tick during WAIT → ignored; overrun_o=1 and stays until err_clr_i; current mix_o unaffected; err_clr_i together with a new overrun → overrun_o stays 1.
- Model withholds ready for voice 1, TIMEOUT_CYCLES=8 → voice 1 abandoned after 8 WAIT cycles; timeout_o=1; voice 2 still processed; mix_o = v0+v2.
- rst_i asserted mid-WAIT of voice 1 → next cycle all outputs 0, state IDLE, no mix_valid_o; a following tick restarts at voice 0 with acc=0.
